// File: rtl/ddr_wr_arb.sv
// ddr_wr_arb: round-robin arbiter sharing one DDR write command/data port
// between NUM_CH line-buffer writers. Latches the winner's command, muxes
// its data and routes controller handshakes back to the granted channel.
// Beat-count checking flags length mismatches. A per-burst watchdog aborts
// bursts that hang.
//
// Handshake contract: a writer holds s_wreq[i] until it sees s_wdata_req[i].
// The arbiter holds m_wreq until the controller's first m_wdata_req. Each
// m_wdata_req cycle consumes one beat of m_wdata. An m_wdone pulse ends the
// burst.
module ddr_wr_arb #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 32,
    parameter int DQ_WIDTH   = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic                           ddr_clk,
    input  logic                           ddr_rst,
    input  logic [NUM_CH-1:0]              s_wreq,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   s_waddr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]    s_wr_len,
    input  logic [NUM_CH*8*DQ_WIDTH-1:0]   s_wdata,
    output logic [NUM_CH-1:0]              s_wrdy,
    output logic [NUM_CH-1:0]              s_wdata_req,
    output logic [NUM_CH-1:0]              s_wdone,
    output logic                           m_wreq,
    output logic [ADDR_WIDTH-1:0]          m_waddr,
    output logic [LEN_WIDTH-1:0]           m_wr_len,
    input  logic                           m_wrdy,
    input  logic                           m_wdata_req,
    input  logic                           m_wdone,
    output logic [8*DQ_WIDTH-1:0]          m_wdata,
    output logic                           busy,
    output logic [2:0]                     grant_id,
    output logic                           len_err,
    output logic                           timeout_err,
    output logic [1:0]                     o_dbg_state
);

    localparam int DW   = 8 * DQ_WIDTH;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [2:0]              r_rr_ptr;
    logic [2:0]              r_grant_id;
    logic                    r_m_wreq;
    logic [ADDR_WIDTH-1:0]   r_m_waddr;
    logic [LEN_WIDTH-1:0]    r_m_wr_len;
    logic [LEN_WIDTH-1:0]    r_beat_cnt;
    logic [WD_W-1:0]         r_wdog;
    logic                    r_len_err;
    logic                    r_timeout_err;

    logic                    w_found;
    logic [2:0]              w_pick;
    logic [3:0]              w_idx;
    logic [NUM_CH-1:0]       w_req_shift;
    logic                    w_grant_en;
    logic                    w_burst_end;
    logic                    w_abort;
    logic                    w_active;
    logic                    w_busy;
    logic                    w_wd_expire;
    logic [LEN_WIDTH-1:0]    w_beat_total;
    logic [NUM_CH-1:0]       w_gnt_oh;
    logic [ADDR_WIDTH-1:0]   w_pick_addr;
    logic [LEN_WIDTH-1:0]    w_pick_len;
    logic [NUM_CH*DW-1:0]    w_data_shift;
    logic [2:0]              w_ptr_nxt;

    assign w_busy       = (r_state != ST_IDLE);
    assign w_active     = (r_state == ST_REQ) || (r_state == ST_DATA);
    assign w_wd_expire  = w_active && (r_wdog == WD_W'(TIMEOUT - 1));
    assign w_beat_total = r_beat_cnt + LEN_WIDTH'(m_wdata_req);
    assign w_gnt_oh     = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant_id;
    assign w_pick_addr  = ADDR_WIDTH'(s_waddr >> (int'(w_pick) * ADDR_WIDTH));
    assign w_pick_len   = LEN_WIDTH'(s_wr_len >> (int'(w_pick) * LEN_WIDTH));
    assign w_data_shift = s_wdata >> (int'(r_grant_id) * DW);
    assign w_ptr_nxt    = (r_grant_id == 3'(NUM_CH - 1)) ? 3'd0 : r_grant_id + 3'd1;

    // Round-robin pick: first requester scanning from r_rr_ptr upward, wrapping
    always_comb begin
        w_found     = 1'b0;
        w_pick      = 3'd0;
        w_idx       = 4'd0;
        w_req_shift = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = {1'b0, r_rr_ptr} + 4'(k);
            if (w_idx >= 4'(NUM_CH)) begin
                w_idx = w_idx - 4'(NUM_CH);
            end
            w_req_shift = s_wreq >> w_idx;
            if (!w_found && w_req_shift[0]) begin
                w_found = 1'b1;
                w_pick  = w_idx[2:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and burst-control strobes; completion wins over the watchdog
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_burst_end = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_wdone) begin
                    w_burst_end = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_wd_expire) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (m_wdata_req) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_wdone) begin
                    w_burst_end = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_wd_expire) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command latch, beat/watchdog counters, sticky errors and pointer rotation
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            r_rr_ptr      <= 3'd0;
            r_grant_id    <= 3'd0;
            r_m_wreq      <= 1'b0;
            r_m_waddr     <= '0;
            r_m_wr_len    <= '0;
            r_beat_cnt    <= '0;
            r_wdog        <= '0;
            r_len_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_m_wreq <= (w_state_nxt == ST_REQ);
            if (w_grant_en) begin
                r_grant_id <= w_pick;
                r_m_waddr  <= w_pick_addr;
                r_m_wr_len <= w_pick_len;
                r_beat_cnt <= '0;
                r_wdog     <= '0;
            end else if (w_active) begin
                r_wdog <= r_wdog + 1'b1;
                if (m_wdata_req) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
            if (w_burst_end && (w_beat_total != r_m_wr_len)) begin
                r_len_err <= 1'b1;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign s_wrdy      = {NUM_CH{m_wrdy & w_busy}} & w_gnt_oh;
    assign s_wdata_req = {NUM_CH{m_wdata_req & w_busy}} & w_gnt_oh;
    assign s_wdone     = {NUM_CH{m_wdone & w_busy}} & w_gnt_oh;
    assign m_wdata     = w_data_shift[DW-1:0];
    assign m_wreq      = r_m_wreq;
    assign m_waddr     = r_m_waddr;
    assign m_wr_len    = r_m_wr_len;
    assign busy        = w_busy;
    assign grant_id    = r_grant_id;
    assign len_err     = r_len_err;
    assign timeout_err = r_timeout_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ddr_wr_arb.sv
// Testbench for ddr_wr_arb: directed bursts, a transaction-level model of
// arbitration and error flags, and a per-cycle compare process.
module tb_ddr_wr_arb;

  localparam int NCH = 4;
  localparam int AW  = 27;
  localparam int LW  = 32;
  localparam int DQW = 32;
  localparam int DW  = 8 * DQW;
  localparam int TO  = 64;
  localparam int AWT = NCH * AW;
  localparam int LWT = NCH * LW;
  localparam int DWT = NCH * DW;

  // ---------------- clock / reset ----------------
  logic ddr_clk = 1'b0;
  logic ddr_rst = 1'b1;
  always #5 ddr_clk = ~ddr_clk;

  logic [NCH-1:0] s_wreq;
  logic [AWT-1:0] s_waddr;
  logic [LWT-1:0] s_wr_len;
  logic [DWT-1:0] s_wdata;
  logic [NCH-1:0] s_wrdy, s_wdata_req, s_wdone;
  logic           m_wreq;
  logic [AW-1:0]  m_waddr;
  logic [LW-1:0]  m_wr_len;
  logic           m_wrdy, m_wdata_req, m_wdone;
  logic [DW-1:0]  m_wdata;
  logic           busy;
  logic [2:0]     grant_id;
  logic           len_err, timeout_err;
  logic [1:0]     dbg_state;

  ddr_wr_arb #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DQW), .TIMEOUT(TO)
  ) dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
    .s_wreq(s_wreq), .s_waddr(s_waddr), .s_wr_len(s_wr_len), .s_wdata(s_wdata),
    .s_wrdy(s_wrdy), .s_wdata_req(s_wdata_req), .s_wdone(s_wdone),
    .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wr_len(m_wr_len),
    .m_wrdy(m_wrdy), .m_wdata_req(m_wdata_req), .m_wdone(m_wdone),
    .m_wdata(m_wdata), .busy(busy), .grant_id(grant_id),
    .len_err(len_err), .timeout_err(timeout_err), .o_dbg_state(dbg_state)
  );

  // ---------------- model state ----------------
  int            mdl_ptr;
  int            mdl_gnt;
  bit            mdl_busy, mdl_wreq, mdl_len_err, mdl_to_err;
  logic [AW-1:0] mdl_addr;
  logic [LW-1:0] mdl_len;
  bit            chk_on;

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  int n_checks;
  int n_errors;
  int cyc;
  int mon_dreq0, mon_done, mon_wreq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [NCH-1:0] req, input int ptr);
    int c;
    int res;
    res = -1;
    for (int k = 0; k < NCH; k++) begin
      c = (ptr + k) % NCH;
      if (res < 0 && ((req >> c) & 4'd1) != 4'd0) res = c;
    end
    return res;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int c);
    return 27'h100 + 27'(c) * 27'h1000;
  endfunction

  task automatic model_reset();
    mdl_ptr = 0; mdl_gnt = 0; mdl_busy = 0; mdl_wreq = 0;
    mdl_len_err = 0; mdl_to_err = 0; mdl_addr = '0; mdl_len = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_data();
    logic [31:0] word;
    s_wdata = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int w = 0; w < 8; w++) begin
        word = 32'((c << 28) | (w << 24) | (cyc & 32'h00FF_FFFF));
        s_wdata = s_wdata | (DWT'(word) << (c * DW + w * 32));
      end
    end
  endtask

  task automatic step();
    @(posedge ddr_clk);
    #1;
    cyc++;
    m_wrdy = cyc[0];
    drive_data();
  endtask

  task automatic set_len(input int len);
    s_wr_len = '0;
    for (int c = 0; c < NCH; c++) s_wr_len = s_wr_len | (LWT'(len) << (c * LW));
  endtask

  // One burst: request, grant, 2 cycles controller latency, beats, done.
  task automatic burst(input logic [NCH-1:0] req, input int len, input int beats,
                       input bit hang, input int rst_at);
    int ch;
    int exp;
    ch = model_pick(req, mdl_ptr);
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL exp_q_empty: got 0 entries required 1");
      exp = -1;
    end else begin
      exp = int'(exp_q.pop_front());
    end
    check("model_pick_lit", 32'(ch), 32'(exp));
    s_wreq = req;
    set_len(len);
    step();
    mdl_busy = 1; mdl_wreq = 1; mdl_gnt = ch; mdl_addr = addr_of(ch); mdl_len = LW'(len);
    @(negedge ddr_clk);
    check("grant_lit", 32'(grant_id), 32'(exp));
    if (hang) begin
      repeat (TO - 1) step();
      step();
      mdl_wreq = 0; mdl_to_err = 1;
    end else begin
      step();
      step();
      for (int i = 0; i < beats; i++) begin
        if (i == rst_at) begin
          ddr_rst = 1; m_wdata_req = 0;
          step();
          model_reset();
          ddr_rst = 0; s_wreq = '0;
          return;
        end
        m_wdata_req = 1;
        step();
        mdl_wreq = 0;
      end
      m_wdata_req = 0;
      m_wdone = 1;
      step();
      m_wdone = 0;
      mdl_wreq = 0;
      if (beats != len) mdl_len_err = 1;
    end
    step();
    mdl_busy = 0;
    mdl_ptr = (ch + 1) % NCH;
    s_wreq = '0;
  endtask

  // ---------------- monitor counters ----------------
  always @(negedge ddr_clk) begin
    if (s_wdata_req[0]) mon_dreq0++;
    if (|s_wdone) mon_done++;
    if (m_wreq) mon_wreq++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge ddr_clk) begin
    logic [NCH-1:0] oh;
    logic [DWT-1:0] sh;
    if (chk_on) begin
      oh = mdl_busy ? NCH'(4'd1 << mdl_gnt) : '0;
      sh = s_wdata >> (mdl_gnt * DW);
      check("m_wreq", 32'(m_wreq), 32'(mdl_wreq));
      check("busy", 32'(busy), 32'(mdl_busy));
      check("grant_id", 32'(grant_id), 32'(mdl_gnt));
      check("m_waddr", 32'(m_waddr), 32'(mdl_addr));
      check("m_wr_len", 32'(m_wr_len), 32'(mdl_len));
      check("len_err", 32'(len_err), 32'(mdl_len_err));
      check("timeout_err", 32'(timeout_err), 32'(mdl_to_err));
      check("s_wdata_req", 32'(s_wdata_req), 32'(m_wdata_req ? oh : '0));
      check("s_wrdy", 32'(s_wrdy), 32'(m_wrdy ? oh : '0));
      check("s_wdone", 32'(s_wdone), 32'(m_wdone ? oh : '0));
      check_w("m_wdata", m_wdata, sh[DW-1:0]);
    end
  end

  // ---------------- directed sequence ----------------
  int snap_d, snap_done, snap_wreq;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; chk_on = 0;
    mon_dreq0 = 0; mon_done = 0; mon_wreq = 0;
    s_wreq = '0; m_wrdy = 0; m_wdata_req = 0; m_wdone = 0;
    s_waddr = '0;
    for (int c = 0; c < NCH; c++) s_waddr = s_waddr | (AWT'(addr_of(c)) << (c * AW));
    set_len(0);
    drive_data();
    model_reset();
    ddr_rst = 1;
    step();
    step();
    ddr_rst = 0;
    chk_on = 1;
    @(negedge ddr_clk);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_m_wreq", 32'(m_wreq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_waddr", 32'(m_waddr), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);

    // controller strobes while idle must be ignored
    step();
    m_wdata_req = 1; m_wdone = 1;
    step();
    step();
    m_wdata_req = 0; m_wdone = 0;
    step();

    // fairness with all channels requesting
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd3); exp_q.push_back(3'd0);
    for (int b = 0; b < 5; b++) burst(4'b1111, 4, 4, 0, -1);

    // single request, ch0, addr 0x100, 40 beats
    snap_d = mon_dreq0; snap_done = mon_done;
    exp_q.push_back(3'd0);
    burst(4'b0001, 40, 40, 0, -1);
    check("t1_m_waddr", 32'(m_waddr), 32'h100);
    check("t1_m_wr_len", 32'(m_wr_len), 32'd40);
    check("t1_dreq0_cnt", 32'(mon_dreq0 - snap_d), 32'd40);
    check("t1_wdone_cnt", 32'(mon_done - snap_done), 32'd1);
    check("t1_len_err", 32'(len_err), 32'd0);

    // priority rotation
    exp_q.push_back(3'd2); burst(4'b0100, 3, 3, 0, -1);
    exp_q.push_back(3'd0); burst(4'b0101, 3, 3, 0, -1);
    exp_q.push_back(3'd2); burst(4'b0101, 3, 3, 0, -1);

    // length mismatch, then a normal burst
    exp_q.push_back(3'd0); burst(4'b0001, 40, 39, 0, -1);
    check("lm_len_err", 32'(len_err), 32'd1);
    exp_q.push_back(3'd1); burst(4'b0010, 8, 8, 0, -1);
    check("lm_len_err_sticky", 32'(len_err), 32'd1);

    // watchdog timeout on ch0, ch1 pending next
    snap_done = mon_done; snap_wreq = mon_wreq;
    exp_q.push_back(3'd0); burst(4'b0011, 16, 0, 1, -1);
    check("to_wreq_cycles", 32'(mon_wreq - snap_wreq), 32'd64);
    check("to_no_wdone", 32'(mon_done - snap_done), 32'd0);
    check("to_timeout_err", 32'(timeout_err), 32'd1);
    check("to_m_wreq", 32'(m_wreq), 32'd0);
    exp_q.push_back(3'd1); burst(4'b0011, 5, 5, 0, -1);

    // reset in the middle of a data phase
    exp_q.push_back(3'd3); burst(4'b1000, 40, 40, 0, 20);
    @(negedge ddr_clk);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_m_wreq", 32'(m_wreq), 32'd0);
    check("mr_grant", 32'(grant_id), 32'd0);
    check("mr_m_waddr", 32'(m_waddr), 32'd0);
    check("mr_m_wr_len", 32'(m_wr_len), 32'd0);
    check("mr_len_err", 32'(len_err), 32'd0);
    check("mr_timeout_err", 32'(timeout_err), 32'd0);
    exp_q.push_back(3'd1); burst(4'b0010, 6, 6, 0, -1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
